// File: rtl/clk_pkg.sv
// Shared types and BCD helpers for the time-setting path.
// Holds FSM states, field limits and wrap-around arithmetic.
package clk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EDIT_H,
    EDIT_M,
    COMMIT
  } state_e;

  typedef struct packed {
    logic [3:0] d;
    logic [3:0] u;
  } bcd2_t;

  localparam logic [3:0] HOUR_MAX_D = 4'd2;
  localparam logic [3:0] HOUR_MAX_U = 4'd3;
  localparam logic [3:0] MIN_MAX_D  = 4'd5;
  localparam logic [3:0] MIN_MAX_U  = 4'd9;
  localparam logic [3:0] BLANK_NONE = 4'b0000;

  localparam bcd2_t HOUR_MAX = {HOUR_MAX_D, HOUR_MAX_U};
  localparam bcd2_t MIN_MAX  = {MIN_MAX_D, MIN_MAX_U};

  function automatic bcd2_t bcd_inc(bcd2_t v, bcd2_t mx);
    bcd2_t r;
    r = v;
    if (v == mx) begin
      r = '0;
    end else if (v.u == 4'd9) begin
      r.u = 4'd0;
      r.d = v.d + 4'd1;
    end else begin
      r.u = v.u + 4'd1;
    end
    return r;
  endfunction

  function automatic bcd2_t bcd_dec(bcd2_t v, bcd2_t mx);
    bcd2_t r;
    r = v;
    if (v == '0) begin
      r = mx;
    end else if (v.u == 4'd0) begin
      r.u = 4'd9;
      r.d = v.d - 4'd1;
    end else begin
      r.u = v.u - 4'd1;
    end
    return r;
  endfunction

  // Out-of-range captures (bad digit or beyond the field max) become 00.
  function automatic bcd2_t bcd_fix(bcd2_t v, bcd2_t mx);
    logic ok;
    ok = (v.d <= 4'd9) && (v.u <= 4'd9) &&
         ((v.d < mx.d) || ((v.d == mx.d) && (v.u <= mx.u)));
    return ok ? v : '0;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, counting debouncer and press pulse.
// press_o is the registered rising edge of the debounced level.
module btn_debounce #(
  parameter int DEB_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DEB_CYCLES - 1);

  logic          s1_q, s2_q;
  logic          db_q, dbp_q;
  logic          press_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      db_q    <= 1'b0;
      dbp_q   <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= btn_i;
      s2_q    <= s1_q;
      dbp_q   <= db_q;
      press_q <= db_q & ~dbp_q;
      if (s2_q != db_q) begin
        if (cnt_q == CMAX) begin
          db_q  <= s2_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/time_set_ctrl.sv
// HH:MM edit controller driven by mode/up/down buttons.
// Emits a one-cycle load on commit and blinks the edited pair.
module time_set_ctrl
  import clk_pkg::*;
#(
  parameter int DEB_CYCLES   = 2_000_000,
  parameter int BLINK_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [3:0] cur_hora_d,
  input  logic [3:0] cur_hora_u,
  input  logic [3:0] cur_min_d,
  input  logic [3:0] cur_min_u,
  output logic [3:0] set_hora_d,
  output logic [3:0] set_hora_u,
  output logic [3:0] set_min_d,
  output logic [3:0] set_min_u,
  output logic       load,
  output logic       editing,
  output logic [3:0] blank
);

  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BW-1:0] BMAX = BW'(BLINK_CYCLES - 1);

  logic pm, pu, pd, step, clr, edit;
  state_e st_q, st_d;
  bcd2_t hr_q, hr_d, mn_q, mn_d;
  logic [BW-1:0] bc_q;
  logic ph_q;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_mode (
    .clk(clk), .reset(reset), .btn_i(btn_mode), .press_o(pm)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_up (
    .clk(clk), .reset(reset), .btn_i(btn_up), .press_o(pu)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_down (
    .clk(clk), .reset(reset), .btn_i(btn_down), .press_o(pd)
  );

  // Mode has priority; up and down together cancel out.
  assign step = pu ^ pd;

  always_comb begin
    st_d = st_q;
    hr_d = hr_q;
    mn_d = mn_q;
    clr  = 1'b0;
    unique case (st_q)
      IDLE: if (pm) begin
        hr_d = bcd_fix({cur_hora_d, cur_hora_u}, HOUR_MAX);
        mn_d = bcd_fix({cur_min_d, cur_min_u}, MIN_MAX);
        st_d = EDIT_H;
        clr  = 1'b1;
      end
      EDIT_H: if (pm) begin
        st_d = EDIT_M;
        clr  = 1'b1;
      end else if (step) begin
        hr_d = pu ? bcd_inc(hr_q, HOUR_MAX) : bcd_dec(hr_q, HOUR_MAX);
        clr  = 1'b1;
      end
      EDIT_M: if (pm) begin
        st_d = COMMIT;
      end else if (step) begin
        mn_d = pu ? bcd_inc(mn_q, MIN_MAX) : bcd_dec(mn_q, MIN_MAX);
        clr  = 1'b1;
      end
      COMMIT: st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q <= IDLE;
      hr_q <= '0;
      mn_q <= '0;
    end else begin
      st_q <= st_d;
      hr_q <= hr_d;
      mn_q <= mn_d;
    end
  end

  assign edit = (st_q == EDIT_H) || (st_q == EDIT_M);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bc_q <= '0;
      ph_q <= 1'b0;
    end else if (clr || !edit) begin
      bc_q <= '0;
      ph_q <= 1'b0;
    end else if (bc_q == BMAX) begin
      bc_q <= '0;
      ph_q <= ~ph_q;
    end else begin
      bc_q <= bc_q + 1'b1;
    end
  end

  always_comb begin
    blank = BLANK_NONE;
    unique case (st_q)
      EDIT_H:  blank = {ph_q, ph_q, 2'b00};
      EDIT_M:  blank = {2'b00, ph_q, ph_q};
      default: blank = BLANK_NONE;
    endcase
  end

  assign load       = (st_q == COMMIT);
  assign editing    = edit;
  assign set_hora_d = hr_q.d;
  assign set_hora_u = hr_q.u;
  assign set_min_d  = mn_q.d;
  assign set_min_u  = mn_q.u;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Random and directed bench for time_set_ctrl against a
// behavioural model of the debounce window and edit rules.
module tb_time_set_ctrl;

  localparam int DEB = 4;
  localparam int BLK = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic [3:0] cur_hora_d = '0, cur_hora_u = '0;
  logic [3:0] cur_min_d = '0, cur_min_u = '0;
  logic [3:0] set_hora_d, set_hora_u, set_min_d, set_min_u;
  logic load, editing;
  logic [3:0] blank;

  time_set_ctrl #(.DEB_CYCLES(DEB), .BLINK_CYCLES(BLK)) dut (
    .clk(clk), .reset(reset),
    .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .cur_hora_d(cur_hora_d), .cur_hora_u(cur_hora_u),
    .cur_min_d(cur_min_d), .cur_min_u(cur_min_u),
    .set_hora_d(set_hora_d), .set_hora_u(set_hora_u),
    .set_min_d(set_min_d), .set_min_u(set_min_u),
    .load(load), .editing(editing), .blank(blank)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int n_load = 0, entries = 0;
  logic [15:0] load_val = '0;
  logic ed_prev = 1'b0;

  // model: 0 idle, 1 edit hour, 2 edit minute, 3 commit
  int hq[3][$];
  bit [2:0] db, q1, p;
  int st, h, m, since;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 3; b++) begin
      hq[b].delete();
      for (int i = 0; i < DEB + 2; i++) hq[b].push_back(0);
    end
    db = '0; q1 = '0; p = '0;
    st = 0; h = 0; m = 0; since = 0;
    ed_prev = 1'b0;
  endtask

  function automatic int cap(int d, int u, int mx);
    if (d > 9 || u > 9 || d * 10 + u > mx) return 0;
    return d * 10 + u;
  endfunction

  task automatic model_tick();
    bit [2:0] r, ap;
    bit all, clr, step;
    r = {btn_down, btn_up, btn_mode};
    ap = p;
    for (int b = 0; b < 3; b++) begin
      p[b] = q1[b];
      hq[b].push_back(int'(r[b]));
      void'(hq[b].pop_front());
      // accept a new level only after DEB consecutive differing samples
      all = 1'b1;
      for (int i = 0; i < DEB; i++)
        if (hq[b][i] == int'(db[b])) all = 1'b0;
      q1[b] = 1'b0;
      if (all) begin
        db[b] = ~db[b];
        q1[b] = db[b];
      end
    end
    clr = 1'b0;
    step = ap[1] != ap[2];
    case (st)
      0: if (ap[0]) begin
        h = cap(int'(cur_hora_d), int'(cur_hora_u), 23);
        m = cap(int'(cur_min_d), int'(cur_min_u), 59);
        st = 1; clr = 1'b1;
      end
      1: if (ap[0]) begin
        st = 2; clr = 1'b1;
      end else if (step) begin
        h = ap[1] ? (h + 1) % 24 : (h + 23) % 24;
        clr = 1'b1;
      end
      2: if (ap[0]) st = 3;
      else if (step) begin
        m = ap[1] ? (m + 1) % 60 : (m + 59) % 60;
        clr = 1'b1;
      end
      default: st = 0;
    endcase
    since = clr ? 0 : since + 1;
  endtask

  task automatic compare();
    logic [15:0] es;
    logic [3:0] eb;
    bit ph;
    es = {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
    ph = ((since / BLK) % 2) == 1;
    eb = 4'b0000;
    if (st == 1 && ph) eb = 4'b1100;
    if (st == 2 && ph) eb = 4'b0011;
    chk("set", 32'({set_hora_d, set_hora_u, set_min_d, set_min_u}),
        32'(es));
    chk("load", 32'(load), 32'(st == 3));
    chk("editing", 32'(editing), 32'(st == 1 || st == 2));
    chk("blank", 32'(blank), 32'(eb));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_tick();
    @(negedge clk);
    compare();
    if (load) begin
      n_load++;
      load_val = {set_hora_d, set_hora_u, set_min_d, set_min_u};
    end
    if (editing && !ed_prev) entries++;
    ed_prev = editing;
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: btn_mode = v;
      1: btn_up = v;
      default: btn_down = v;
    endcase
  endtask

  task automatic press2(input int b1, input int b2);
    set_btn(b1, 1'b1);
    set_btn(b2, 1'b1);
    repeat (10) cyc();
    set_btn(b1, 1'b0);
    set_btn(b2, 1'b0);
    repeat (10) cyc();
  endtask

  task automatic press(input int b);
    press2(b, b);
  endtask

  task automatic set_cur(input int hd, input int hu, input int md,
                         input int mu);
    cur_hora_d = 4'(hd); cur_hora_u = 4'(hu);
    cur_min_d = 4'(md); cur_min_u = 4'(mu);
  endtask

  function automatic logic [7:0] hr();
    return {set_hora_d, set_hora_u};
  endfunction

  function automatic logic [7:0] mn();
    return {set_min_d, set_min_u};
  endfunction

  initial begin
    int n, e0, l0;
    int tmr[3];
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_set", 32'({set_hora_d, set_hora_u, set_min_d, set_min_u}), 0);
    chk("rst_load", 32'(load), 0);
    chk("rst_edit", 32'(editing), 0);
    chk("rst_blank", 32'(blank), 0);

    // bouncing mode button, then held
    set_cur(2, 3, 5, 9);
    e0 = entries;
    for (int i = 0; i < 5; i++) begin
      btn_mode = (i % 2 == 1);
      repeat (2) cyc();
    end
    btn_mode = 1'b1;
    n = 0;
    while (!editing && n < 20) begin
      cyc();
      n++;
    end
    chk("bounce_lat", 32'(n), 32'(2 + DEB + 2));
    repeat (8) cyc();
    btn_mode = 1'b0;
    repeat (10) cyc();
    chk("bounce_once", 32'(entries - e0), 1);

    press(1);
    chk("h_wrap_up", 32'(hr()), 32'h00);
    press(0);
    press(1);
    chk("m_wrap_up", 32'(mn()), 32'h00);
    l0 = n_load;
    press(0);
    chk("load_once", 32'(n_load - l0), 1);
    chk("load_val0", 32'(load_val), 32'h0000);
    chk("edit_off", 32'(editing), 0);

    set_cur(0, 0, 0, 0);
    press(0);
    press(2);
    chk("h_wrap_dn", 32'(hr()), 32'h23);
    press(0);
    press(2);
    chk("m_wrap_dn", 32'(mn()), 32'h59);
    press(0);

    set_cur(1, 9, 0, 0);
    press(0);
    press(1);
    chk("h_carry", 32'(hr()), 32'h20);
    repeat (20) cyc();
    press2(1, 2);
    chk("ud_ignored", 32'(hr()), 32'h20);
    press2(0, 1);
    chk("mode_wins", 32'(hr()), 32'h20);
    chk("mode_wins_ed", 32'(editing), 1);
    repeat (20) cyc();
    press(0);
    chk("commit_val", 32'(load_val), 32'h2000);

    set_cur(3, 10, 7, 15);
    press(0);
    press(0);
    press(0);
    chk("inv_capture", 32'(load_val), 32'h0000);

    set_cur(1, 2, 3, 4);
    press(0);
    press(0);
    repeat (3) cyc();
    l0 = n_load;
    #2 reset = 1'b1;
    #1;
    chk("arst_set", 32'({set_hora_d, set_hora_u, set_min_d, set_min_u}),
        0);
    chk("arst_out", 32'({load, editing, blank}), 0);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) cyc();
    chk("arst_noload", 32'(n_load - l0), 0);

    for (int b = 0; b < 3; b++) tmr[b] = $urandom_range(1, 14);
    for (int c = 0; c < 3000; c++) begin
      if (c % 40 == 0)
        set_cur($urandom_range(0, 3), $urandom_range(0, 10),
                $urandom_range(0, 6), $urandom_range(0, 10));
      for (int b = 0; b < 3; b++) begin
        if (tmr[b] == 0) begin
          case (b)
            0: btn_mode = ~btn_mode;
            1: btn_up = ~btn_up;
            default: btn_down = ~btn_down;
          endcase
          tmr[b] = $urandom_range(1, 14);
        end else begin
          tmr[b]--;
        end
      end
      cyc();
    end
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    repeat (20) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
Input-side companion to the 7-segment display path. Takes the three raw Basys 3 push-buttons (mode/up/down) and lets the user edit the HH:MM time held by the Clock counter. Buttons are synchronised and debounced, a set-mode FSM is run, and on commit the block emits one load pulse with the new BCD time. It also drives a per-digit blank mask so the digit pair being edited blinks on the display.

Parameters:
DEB_CYCLES, 2_000_000, consecutive stable cycles before a button change is accepted (20 ms at 100 MHz).
BLINK_CYCLES, 25_000_000, cycles per blink half-period (2 Hz toggle at 100 MHz).

Ports:
clk  in  1  system clock (100 MHz)
reset  in  1  asynchronous, active-high reset
btn_mode  in  1  raw mode button, asynchronous to clk
btn_up  in  1  raw increment button
btn_down  in  1  raw decrement button
cur_hora_d  in  4  current hour tens (BCD), sampled on edit entry
cur_hora_u  in  4  current hour units (BCD)
cur_min_d  in  4  current minute tens (BCD)
cur_min_u  in  4  current minute units (BCD)
set_hora_d  out  4  edited hour tens (BCD)
set_hora_u  out  4  edited hour units
set_min_d  out  4  edited minute tens
set_min_u  out  4  edited minute units
load  out  1  one-cycle pulse: Clock loads the set_* values
editing  out  1  high in any edit state
blank  out  4  per-digit blank mask, bit3=hora_d ... bit0=min_u; 1 = digit off

Behaviour:
- Reset (async, active-high): every output is 0, FSM is IDLE, debouncers hold 0, blink phase is 0 and the blink counter is 0.
- Each button path: a 2-FF synchroniser feeds a debouncer.
  - The counter increments while the synced value differs from the debounced value and clears when they match.
  - When the counter reaches DEB_CYCLES-1 and the values still differ, the debounced value flips on the next edge.
  - The press pulse is the registered rising edge of the debounced value.
  - Latency from a clean raw edge to the edit register updating is 2+DEB_CYCLES+2 clock edges, exactly.
- Releases and bounces shorter than DEB_CYCLES produce no press.
- FSM states: IDLE, EDIT_H, EDIT_M, COMMIT.
  - IDLE + mode press: capture cur_* into the edit registers and go to EDIT_H. If the captured hour is >23, the minute is >59, or any digit is >9, that field is replaced with 00.
  - EDIT_H: up increments the hour 00..23 (23 wraps to 00); down decrements it (00 wraps to 23). Mode press goes to EDIT_M.
  - EDIT_M: up/down act on the minute 00..59 with the same wrap rules (59 to 00, 00 to 59). Mode press goes to COMMIT.
  - COMMIT: assert load for exactly one cycle, then go to IDLE.
- set_* are valid in every state. They stay at the last edited or committed value while in IDLE.
- BCD arithmetic:
  - Increment: at the field maximum, go to 00; else if units==9, units=0 and tens+1; else units+1.
  - Decrement: at 00, go to the field maximum; else if units==0, units=9 and tens-1; else units-1.
- Simultaneous press pulses in one cycle:
  - mode together with up or down: mode wins and the others are ignored.
  - up together with down: both are ignored.
- up/down presses in IDLE or COMMIT are ignored.
- Blink:
  - On entry to EDIT_H/EDIT_M, and on every accepted up/down press, the blink counter and phase clear to 0 (digits visible).
  - The phase toggles every BLINK_CYCLES.
  - blank = {ph,ph,0,0} in EDIT_H, {0,0,ph,ph} in EDIT_M, 0000 otherwise.
- editing = 1 in EDIT_H and EDIT_M; 0 in IDLE and COMMIT.
- Reset mid-edit: return to IDLE with no load pulse. The edit is discarded.
- Holding a button gives one press only; there is no auto-repeat.

Decomposition:
- Package clk_pkg:
  - state enum (IDLE, EDIT_H, EDIT_M, COMMIT)
  - BCD limit constants HOUR_MAX_D=2, HOUR_MAX_U=3, MIN_MAX_D=5, MIN_MAX_U=9
  - BLANK_NONE = 4'b0000
- Sub-module btn_debounce (synchroniser + debouncer + rising-edge pulse, parameter DEB_CYCLES), instantiated three times.

Test Plan:
- Setup: DEB_CYCLES=4, BLINK_CYCLES=8. A bouncing mode input (toggling every 2 cycles for 10 cycles, then held) -> exactly one EDIT_H entry, occurring 2+4+2 edges after the final stable edge.
- Current time 23:59, mode, then up in EDIT_H -> set_hora 00. Then mode, up -> set_min 00. Then mode -> one-cycle load with set_* = 0,0,0,0; editing returns to 0.
- Current time 00:00, mode, down -> hour 23; mode, down -> minute 59; hour 19 with up -> 20 (BCD carry).
- In EDIT_H with no presses -> blank alternates 0000 and 1100 every 8 cycles. An up press forces blank=0000 on the following cycle.
- up and down pulses in the same cycle -> edit value unchanged. Mode with up in the same cycle in EDIT_H -> state EDIT_M and hour unchanged.
- Captured time 3A:7F (invalid), edit, commit with no changes -> load with 00:00. Reset asserted in EDIT_M -> all outputs 0 asynchronously and no load pulse.
